// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//  - WIDTH_* : access-width control encodings shared with the decode stage
//  - lsu_state_t : handshake FSM states
//  - width_cls_t : width class (8/16/32) derived from a WIDTH_* encoding
//  - width_class(), align_ok(), be_gen() : width decode, alignment check, byte enables
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] WIDTH_8S  = 3'b000;
  localparam logic [2:0] WIDTH_16S = 3'b001;
  localparam logic [2:0] WIDTH_32  = 3'b010;
  localparam logic [2:0] WIDTH_8U  = 3'b100;
  localparam logic [2:0] WIDTH_16U = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    WCLS_8  = 2'd0,
    WCLS_16 = 2'd1,
    WCLS_32 = 2'd2
  } width_cls_t;

  // Unrecognised encodings fall back to a full-word access.
  function automatic width_cls_t width_class(input logic [2:0] w);
    case (w)
      WIDTH_8S, WIDTH_8U:   return WCLS_8;
      WIDTH_16S, WIDTH_16U: return WCLS_16;
      default:              return WCLS_32;
    endcase
  endfunction

  function automatic logic align_ok(input width_cls_t c, input logic [1:0] a);
    case (c)
      WCLS_8:  return 1'b1;
      WCLS_16: return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input width_cls_t c, input logic [1:0] a);
    case (c)
      WCLS_8:  return 4'b0001 << a;
      WCLS_16: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//  cls         in   width class of the captured access
//  addr_lo     in   byte offset within the word (addr[1:0])
//  wdata       in   store data, low bytes significant
//  rdata       in   raw bus read word
//  be          out  byte enables
//  wdata_lanes out  store data replicated across all matching lanes
//  rdata_shift out  read word shifted so the addressed byte lands at [7:0]
module lsu_align
  import lsu_pkg::*;
(
  input  width_cls_t  cls,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_shift
);

  assign be = be_gen(cls, addr_lo);

  // Replicating the store data means the byte enables alone pick the lane.
  always_comb begin
    case (cls)
      WCLS_8:  wdata_lanes = {4{wdata[7:0]}};
      WCLS_16: wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase
  end

  // Zero-filled; sign/zero extension happens downstream.
  assign rdata_shift = rdata >> {addr_lo, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit owning the data-bus handshake.
//  clk_i, rst_n_i            clock, asynchronous active-low reset
//  mem_req_valid_i, mem_we_i M-stage access request and direction (1 = store)
//  addr_i, write_data_i      byte address and store data
//  width_src_i               WIDTH_* access width
//  stall_o                   holds IF..M while a transfer is in flight
//  misalign_o                single-cycle pulse when a misaligned access is rejected
//  load_data_o, load_valid_o shifted read word, valid in DONE for loads
//  bus_*                     word-aligned request with byte enables; gnt/rvalid handshake
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_req_valid_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic [2:0]  width_src_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  lsu_state_t  state, state_nxt;

  logic        we_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  width_cls_t  cls_p1;
  logic [31:0] load_data_p1;

  width_cls_t  cls_p0;
  logic        aligned_p0;
  logic        cap_req;
  logic        cap_rd;
  logic [31:0] rdata_shift;

  assign cls_p0     = width_class(width_src_i);
  assign aligned_p0 = align_ok(cls_p0, addr_i[1:0]);

  lsu_align u_align (
    .cls         (cls_p1),
    .addr_lo     (addr_p1[1:0]),
    .wdata       (wdata_p1),
    .rdata       (bus_rdata_i),
    .be          (bus_be_o),
    .wdata_lanes (bus_wdata_o),
    .rdata_shift (rdata_shift)
  );

  // Stage p0 -> p1: capture of the accepted request and of load data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      we_p1        <= 1'b0;
      addr_p1      <= '0;
      wdata_p1     <= '0;
      cls_p1       <= WCLS_8;
      load_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (cap_req) begin
        we_p1    <= mem_we_i;
        addr_p1  <= addr_i;
        wdata_p1 <= write_data_i;
        cls_p1   <= cls_p0;
      end
      if (cap_rd) begin
        load_data_p1 <= rdata_shift;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cap_req      = 1'b0;
    cap_rd       = 1'b0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_req_o    = 1'b0;
    load_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_req_valid_i) begin
          if (aligned_p0) begin
            cap_req   = 1'b1;
            stall_o   = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      ST_REQ: begin
        bus_req_o = 1'b1;
        stall_o   = 1'b1;
        if (bus_gnt_i) begin
          if (we_p1) begin
            state_nxt = ST_DONE;
          end else if (bus_rvalid_i) begin
            cap_rd    = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_WAIT_R;
          end
        end
      end
      ST_WAIT_R: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          cap_rd    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        load_valid_o = ~we_p1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Keep the request-driven outputs quiet while reset is asserted.
    if (!rst_n_i) begin
      stall_o    = 1'b0;
      misalign_o = 1'b0;
    end
  end

  assign bus_we_o    = we_p1;
  assign bus_addr_o  = {addr_p1[31:2], 2'b00};
  assign load_data_o = load_data_p1;

endmodule
